// File: rtl/mdio_if.sv
// Purpose : Clause-22 MDIO master; turns one op request into a 64-bit MDC frame and returns read data.
// Latency : op_done pulses 128*DIV clk after accept; read data valid in op_dout on that same edge.
// Backpr. : none; op_ena is sampled only while IDLE, requests during a frame are dropped (no queueing).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   mdc, mdt, mdo, mdi  MDIO pins (external tri-state: mdio = mdt ? mdo : 'z, mdi = mdio)
//   op_ena              one-cycle request; op_rdwr 1=write 0=read; op_phya/op_rega addresses; op_din write data
//   op_dout             last completed read word, held until the next read completes
//   op_done             one-cycle pulse at the end of every frame
module mdio_if #(
    parameter int DIV = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mdc,
    output logic        mdt,
    output logic        mdo,
    input  logic        mdi,
    input  logic        op_ena,
    input  logic        op_rdwr,
    input  logic [4:0]  op_phya,
    input  logic [4:0]  op_rega,
    input  logic [15:0] op_din,
    output logic [15:0] op_dout,
    output logic        op_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    // Half-period index: even value 2n = low half of bit n, odd value = high half.
    logic [6:0]    hcnt, hcnt_nxt;
    logic [5:0]    cur_bit, nxt_bit;
    logic [63:0]   frame;
    logic [63:0]   tx_sr, tx_sr_nxt;
    logic [15:0]   rx_sr, rx_sr_nxt;
    logic [15:0]   dout_nxt;
    logic          is_rd, is_rd_nxt;
    logic          mdc_nxt, mdt_nxt, mdo_nxt, done_nxt;
    logic          tick;

    // For reads the TA and data fields are filled with 1s so mdo idles high
    // while the line is released.
    assign frame = {32'hFFFF_FFFF, 2'b01,
                    op_rdwr ? 2'b01 : 2'b10,
                    op_phya, op_rega,
                    op_rdwr ? 2'b10 : 2'b11,
                    op_rdwr ? op_din : 16'hFFFF};

    assign tick    = (cnt == CW'(DIV - 1));
    assign cur_bit = hcnt[6:1];
    assign nxt_bit = hcnt[6:1] + 6'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hcnt_nxt  = hcnt;
        mdc_nxt   = mdc;
        mdt_nxt   = mdt;
        mdo_nxt   = mdo;
        tx_sr_nxt = tx_sr;
        rx_sr_nxt = rx_sr;
        is_rd_nxt = is_rd;
        dout_nxt  = op_dout;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                mdc_nxt  = 1'b0;
                mdt_nxt  = 1'b0;
                mdo_nxt  = 1'b1;
                cnt_nxt  = '0;
                hcnt_nxt = '0;
                if (op_ena) begin
                    state_nxt = SHIFT;
                    is_rd_nxt = ~op_rdwr;
                    mdt_nxt   = 1'b1;
                    mdo_nxt   = frame[63];
                    tx_sr_nxt = {frame[62:0], 1'b1};
                end
            end

            SHIFT: begin
                if (!tick) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    cnt_nxt  = '0;
                    hcnt_nxt = hcnt + 7'd1;
                    if (!hcnt[0]) begin
                        // Rising MDC edge of cur_bit: capture read data bits 48..63.
                        mdc_nxt = 1'b1;
                        if (is_rd && (cur_bit >= 6'd48))
                            rx_sr_nxt = {rx_sr[14:0], mdi};
                    end else if (hcnt == 7'd127) begin
                        // Final falling edge closes the frame.
                        state_nxt = IDLE;
                        mdc_nxt   = 1'b0;
                        mdt_nxt   = 1'b0;
                        mdo_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        if (is_rd)
                            dout_nxt = rx_sr;
                    end else begin
                        // Falling MDC edge: launch nxt_bit.
                        mdc_nxt   = 1'b0;
                        mdo_nxt   = tx_sr[63];
                        tx_sr_nxt = {tx_sr[62:0], 1'b1};
                        mdt_nxt   = !is_rd || (nxt_bit < 6'd46);
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hcnt    <= '0;
            mdc     <= 1'b0;
            mdt     <= 1'b0;
            mdo     <= 1'b1;
            tx_sr   <= '1;
            rx_sr   <= '0;
            is_rd   <= 1'b0;
            op_dout <= '0;
            op_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hcnt    <= hcnt_nxt;
            mdc     <= mdc_nxt;
            mdt     <= mdt_nxt;
            mdo     <= mdo_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            is_rd   <= is_rd_nxt;
            op_dout <= dout_nxt;
            op_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_mdio_if.sv
// Purpose : directed bench for mdio_if; expected frame bits queued at request, popped at each MDC rise.
// Latency : checks op_done exactly 128*DIV clk after accept and per-cycle MDC/MDT shape.
// Backpr. : exercises ignored requests mid-frame, reset abort and back-to-back ops.
module tb_mdio_if;

    localparam int DIV = 10;
    localparam int FR  = 128 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdc, mdt, mdo, mdi;
    logic        op_ena, op_rdwr;
    logic [4:0]  op_phya, op_rega;
    logic [15:0] op_din, op_dout;
    logic        op_done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_dout;
    logic        sb_bit[$];

    mdio_if #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .mdc     (mdc),
        .mdt     (mdt),
        .mdo     (mdo),
        .mdi     (mdi),
        .op_ena  (op_ena),
        .op_rdwr (op_rdwr),
        .op_phya (op_phya),
        .op_rega (op_rega),
        .op_din  (op_din),
        .op_dout (op_dout),
        .op_done (op_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check({nm, " idle mdc"}, mdc, 1'b0);
            check({nm, " idle mdt"}, mdt, 1'b0);
            check({nm, " idle mdo"}, mdo, 1'b1);
            check({nm, " idle op_done"}, op_done, 1'b0);
        end
    endtask

    // One frame: request, per-cycle shape checks, PHY model on mdi, optional
    // stray op_ena at bit ena_bit (and on the op_done edge), optional reset at bit rst_bit.
    task automatic run_op(input string nm, input logic rdwr, input logic [4:0] pa,
                          input logic [4:0] ra, input logic [15:0] din,
                          input logic [15:0] pdat, input int ena_bit, input int rst_bit);
        logic [63:0] fr;
        logic        prev;
        int          nrise;
        int          nb;
        logic        exp_bit;

        fr = {32'hFFFF_FFFF, 2'b01, rdwr ? 2'b01 : 2'b10, pa, ra,
              rdwr ? 2'b10 : 2'b11, rdwr ? din : 16'hFFFF};
        for (int i = 0; i < 64; i++) sb_bit.push_back(fr[63-i]);

        op_ena = 1'b1; op_rdwr = rdwr; op_phya = pa; op_rega = ra; op_din = din;
        step();
        // Scramble the request fields: the frame must use the latched copies.
        op_ena = 1'b0; op_rdwr = ~rdwr; op_phya = ~pa; op_rega = ~ra; op_din = ~din;
        check({nm, " accept mdt"}, mdt, 1'b1);
        check({nm, " accept mdc"}, mdc, 1'b0);
        check({nm, " accept mdo"}, mdo, 1'b1);
        check({nm, " accept op_done"}, op_done, 1'b0);

        prev  = 1'b0;
        nrise = 0;
        for (int t = 1; t <= FR; t++) begin
            op_ena = (ena_bit >= 0) && ((t == 2 * ena_bit * DIV) || (t == FR));
            if (rst_bit >= 0 && t == 2 * rst_bit * DIV + 3) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check({nm, " rst mdc"}, mdc, 1'b0);
                check({nm, " rst mdt"}, mdt, 1'b0);
                check({nm, " rst mdo"}, mdo, 1'b1);
                check({nm, " rst op_dout"}, op_dout, 16'h0000);
                check({nm, " rst op_done"}, op_done, 1'b0);
                exp_dout = 16'h0000;
                sb_bit.delete();
                mdi = 1'b1;
                return;
            end
            step();
            check({nm, " mdc"}, mdc, ((t / DIV) % 2) == 1);
            check({nm, " mdt"}, mdt, rdwr ? (t < FR) : (t < 92 * DIV));
            check({nm, " op_done"}, op_done, t == FR);
            if (t == FR - 1) check({nm, " op_dout before end"}, op_dout, exp_dout);
            if (mdc && !prev) begin
                nrise++;
                if (sb_bit.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL %s scoreboard: observed extra mdc rise %0d, expected 64 rises", nm, nrise);
                end else begin
                    exp_bit = sb_bit.pop_front();
                    check({nm, " mdo bit"}, mdo, exp_bit);
                end
                // PHY model: present the next bit before the next rising edge.
                nb = nrise;
                if (nb >= 48 && nb <= 63) mdi = pdat[63-nb];
                else if (nb == 47)        mdi = 1'b0;
                else                      mdi = 1'b1;
            end
            prev = mdc;
        end
        op_ena = 1'b0;
        mdi    = 1'b1;
        if (!rdwr) exp_dout = pdat;
        check({nm, " op_dout at end"}, op_dout, exp_dout);
        check({nm, " mdc rise count"}, nrise, 64);
        check({nm, " scoreboard empty"}, sb_bit.size(), 0);
    endtask

    initial begin
        rst = 1'b1; op_ena = 1'b0; op_rdwr = 1'b0; op_phya = '0; op_rega = '0;
        op_din = '0; mdi = 1'b1; exp_dout = 16'h0000;
        step();
        step();
        check("reset mdc", mdc, 1'b0);
        check("reset mdt", mdt, 1'b0);
        check("reset mdo", mdo, 1'b1);
        check("reset op_dout", op_dout, 16'h0000);
        check("reset op_done", op_done, 1'b0);
        rst = 1'b0;
        idle("post_reset", 5);

        run_op("wr1", 1'b1, 5'b10001, 5'b10001, 16'h1111, 16'h0000, -1, -1);
        idle("wr1", 5);
        run_op("rd1", 1'b0, 5'b10001, 5'b10001, 16'h0000, 16'hA5C3, -1, -1);
        idle("rd1", 5);
        run_op("wr_ena", 1'b1, 5'b01010, 5'b00101, 16'hBEEF, 16'h0000, 20, -1);
        idle("wr_ena", 30);
        run_op("rd_rst", 1'b0, 5'b10001, 5'b10001, 16'h0000, 16'h1234, -1, 40);
        idle("rd_rst", 5);
        run_op("wr_after_rst", 1'b1, 5'b00011, 5'b11100, 16'h8001, 16'h0000, -1, -1);
        idle("wr_after_rst", 3);
        run_op("rd_b2b", 1'b0, 5'b00001, 5'b00010, 16'h0000, 16'h0F0F, -1, -1);
        run_op("wr_b2b", 1'b1, 5'b11111, 5'b00000, 16'h7E81, 16'h0000, -1, -1);
        check("b2b op_dout held", op_dout, 16'h0F0F);
        idle("final", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
